dual_port_ram_sync: RTL and testbench
=====================================

# dual_port_ram_sync

Synchronous, parametrised dual-port RAM. It is the clocked successor to the asynchronous dual-port RAM and sits in the same memory subsystem. Two independent request ports share one storage array. A hardware init sweep zeroes the array after reset, and same-address collisions are resolved deterministically with a selectable read mode and write arbitration policy.

## Interface
- D_WIDTH, 8, data width in bits
- A_WIDTH, 8, address width; DEPTH = 2**A_WIDTH words
- READ_MODE, 0, read/write same-address behaviour: 0 = read-first (old data), 1 = write-through (new data)
- PRIORITY, 0, write-collision policy: 0 = left port always wins, 1 = round-robin

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- ready  out  1  high when init sweep is complete and requests are accepted
- req_l / req_r  in  1  port request, sampled each rising edge
- we_l / we_r  in  1  1 = write, 0 = read (valid with req)
- addr_l / addr_r  in  A_WIDTH  port address
- wdata_l / wdata_r  in  D_WIDTH  write data
- rdata_l / rdata_r  out  D_WIDTH  registered read data
- rvalid_l / rvalid_r  out  1  one-cycle pulse; rdata valid
- wdrop_l / wdrop_r  out  1  one-cycle pulse; this port's write lost arbitration
- coll  out  1  one-cycle pulse on any same-address access where at least one port writes

## Operation
- Two-state FSM:
  - INIT: entered on any edge with rst=0. Clear counter = 0. Each edge with rst=1 writes 0 to mem[counter], then increments counter. After writing DEPTH-1, the next state is RUN.
  - RUN: normal service. The FSM remains in RUN until rst=0.
- Reset values, applied at any edge with rst=0 (including mid-sweep or mid-operation):
  - ready=0; rdata_l = rdata_r = 0; rvalid_* = 0; wdrop_* = 0; coll = 0
  - round-robin pointer = left
  - counter = 0
  - In-flight requests are discarded.
- Requests made while ready=0 are ignored: no write, no rvalid, no flags.
- In RUN, a port access is accepted on every edge where req=1. Each port may issue one access per cycle.
- Different addresses: both ports operate independently.
- Same address, both read: both return mem[addr].
- Same address, one read and one write:
  - The write always commits.
  - The reader returns the old word if READ_MODE=0, or the writer's wdata if READ_MODE=1.
  - coll pulses.
- Same address, both write:
  - Only the winner's data commits; the loser's wdrop pulses; coll pulses.
  - PRIORITY=0: left always wins.
  - PRIORITY=1: the pointer port wins, then the pointer moves to the losing port. The pointer changes only on write-write collisions.
- rdata holds its last value when no read is accepted on that port.

## Timing
- Init: ready rises at the DEPTH-th consecutive rising edge with rst=1. Example: DEPTH=16 gives ready high after edge 16.
- Write: mem updates at the accepting edge. A read of the same address accepted on the next edge returns the new data.
- Read latency is 1 cycle: a read accepted at edge k drives rdata and rvalid=1 after edge k, and rvalid clears after edge k+1 unless another read is accepted.
- wdrop and coll assert after the accepting edge k, for one cycle.
- Back-to-back accesses on every edge are supported at full throughput with no bubbles.
- rst=0 at edge k: all outputs take their reset values after edge k, and the INIT sweep restarts from address 0.

## Test plan
1. Init, with A_WIDTH=4. Preload the array by writing 0xAA to all addresses, then pulse rst low for 1 cycle. Required: ready is low for exactly 16 edges, and reads of every address return 0x00.
2. Independent ports. Left writes 0x5A to address 3 while right writes 0xC3 to address 9 in the same cycle; next cycle, left reads 9 and right reads 3. Required: rdata_l=0xC3, rdata_r=0x5A, rvalid pulses for 1 cycle, coll=0.
3. Read/write collision. mem[7]=0x11; left writes 0x22 to address 7 while right reads 7. Required: rdata_r=0x11 with READ_MODE=0, or 0x22 with READ_MODE=1. In both modes coll=1 and mem[7]=0x22 afterwards.
4. Round-robin writes, PRIORITY=1. Three consecutive cycles of both ports writing address 5 (left 0x01/0x03/0x05, right 0x02/0x04/0x06). Required: final mem[5]=0x05; wdrop_r pulses in cycles 1 and 3, wdrop_l in cycle 2. Repeating with PRIORITY=0 gives mem[5]=0x05 with wdrop_r pulsing in all three cycles.
5. Reset mid-operation. Assert rst=0 while a read is in flight and at sweep counter 6. Required:
   - The next cycle shows rvalid=0 and rdata=0.
   - ready stays low for 16 further edges.
   - Requests during the sweep produce no rvalid and leave the memory unchanged.

Source files
------------

// File: rtl/dual_port_ram_sync_if.sv
// dual_port_ram_sync request/response bundle.
// Left and right ports plus shared status flags.
interface dual_port_ram_sync_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
);
  logic               ready;
  logic               req_l;
  logic               we_l;
  logic [A_WIDTH-1:0] addr_l;
  logic [D_WIDTH-1:0] wdata_l;
  logic [D_WIDTH-1:0] rdata_l;
  logic               rvalid_l;
  logic               wdrop_l;
  logic               req_r;
  logic               we_r;
  logic [A_WIDTH-1:0] addr_r;
  logic [D_WIDTH-1:0] wdata_r;
  logic [D_WIDTH-1:0] rdata_r;
  logic               rvalid_r;
  logic               wdrop_r;
  logic               coll;

  modport master (
    input  ready,
    output req_l, we_l, addr_l, wdata_l,
    input  rdata_l, rvalid_l, wdrop_l,
    output req_r, we_r, addr_r, wdata_r,
    input  rdata_r, rvalid_r, wdrop_r,
    input  coll
  );

  modport slave (
    output ready,
    input  req_l, we_l, addr_l, wdata_l,
    output rdata_l, rvalid_l, wdrop_l,
    input  req_r, we_r, addr_r, wdata_r,
    output rdata_r, rvalid_r, wdrop_r,
    output coll
  );
endinterface

// File: rtl/dual_port_ram_sync.sv
// Synchronous dual-port RAM with zeroing init sweep
// and deterministic same-address collision handling.
module dual_port_ram_sync #(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 8,
  parameter int READ_MODE = 0,
  parameter int PRIORITY  = 0
) (
  input logic clk,
  input logic rst,
  dual_port_ram_sync_if.slave bus
);
  localparam int DEPTH = 2 ** A_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [A_WIDTH-1:0] cnt;
  logic [A_WIDTH-1:0] cnt_nxt;
  logic               ptr;

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic ready;
  logic acc_l;
  logic acc_r;
  logic wr_l;
  logic wr_r;
  logic rd_l;
  logic rd_r;
  logic same;
  logic ww;
  logic win_l;
  logic commit_l;
  logic commit_r;
  logic fwd_l;
  logic fwd_r;
  logic hit;

  assign ready     = (state == RUN);
  assign bus.ready = ready;

  // Requests on a reset edge are dropped with the rest of the state.
  assign acc_l = ready & rst & bus.req_l;
  assign acc_r = ready & rst & bus.req_r;
  assign wr_l  = acc_l & bus.we_l;
  assign wr_r  = acc_r & bus.we_r;
  assign rd_l  = acc_l & ~bus.we_l;
  assign rd_r  = acc_r & ~bus.we_r;
  assign same  = (bus.addr_l == bus.addr_r);
  assign ww    = wr_l & wr_r & same;
  assign hit   = acc_l & acc_r & same & (bus.we_l | bus.we_r);

  // Pointer 0 means left holds the round-robin token.
  assign win_l    = (PRIORITY == 0) || !ptr;
  assign commit_l = wr_l & ~(ww & ~win_l);
  assign commit_r = wr_r & ~(ww & win_l);

  // Write-through forwards the other port's data on a hit.
  assign fwd_l = (READ_MODE == 1) & rd_l & wr_r & same;
  assign fwd_r = (READ_MODE == 1) & rd_r & wr_l & same;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sweep advances one word per edge, then hands over to RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = '0;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Storage: zeroing sweep during INIT, arbitrated writes in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else begin
        if (commit_l) mem[bus.addr_l] <= bus.wdata_l;
        if (commit_r) mem[bus.addr_r] <= bus.wdata_r;
      end
    end
  end

  // Registered read data, pulses and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.rdata_l  <= '0;
      bus.rdata_r  <= '0;
      bus.rvalid_l <= 1'b0;
      bus.rvalid_r <= 1'b0;
      bus.wdrop_l  <= 1'b0;
      bus.wdrop_r  <= 1'b0;
      bus.coll     <= 1'b0;
      ptr          <= 1'b0;
    end else begin
      bus.rvalid_l <= rd_l;
      bus.rvalid_r <= rd_r;
      bus.wdrop_l  <= wr_l & ~commit_l;
      bus.wdrop_r  <= wr_r & ~commit_r;
      bus.coll     <= hit;
      if (rd_l) begin
        bus.rdata_l <= fwd_l ? bus.wdata_r : mem[bus.addr_l];
      end
      if (rd_r) begin
        bus.rdata_r <= fwd_r ? bus.wdata_l : mem[bus.addr_r];
      end
      if (ww && PRIORITY == 1) ptr <= win_l;
    end
  end
endmodule

// File: tb/tb_dual_port_ram_sync.sv
// Directed bench for dual_port_ram_sync.
// dut0: read-first/left-wins, dut1: write-through/round-robin.
module tb_dual_port_ram_sync;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dual_port_ram_sync_if #(.D_WIDTH(8), .A_WIDTH(4)) b0 ();
  dual_port_ram_sync_if #(.D_WIDTH(8), .A_WIDTH(4)) b1 ();

  dual_port_ram_sync #(
    .D_WIDTH(8), .A_WIDTH(4), .READ_MODE(0), .PRIORITY(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  dual_port_ram_sync #(
    .D_WIDTH(8), .A_WIDTH(4), .READ_MODE(1), .PRIORITY(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  logic [7:0] rdl [2];
  logic [7:0] rdr [2];
  logic       rvl [2];
  logic       rvr [2];
  logic       wdl [2];
  logic       wdr [2];
  logic       col [2];
  logic       rdy [2];

  assign rdl[0] = b0.rdata_l;
  assign rdl[1] = b1.rdata_l;
  assign rdr[0] = b0.rdata_r;
  assign rdr[1] = b1.rdata_r;
  assign rvl[0] = b0.rvalid_l;
  assign rvl[1] = b1.rvalid_l;
  assign rvr[0] = b0.rvalid_r;
  assign rvr[1] = b1.rvalid_r;
  assign wdl[0] = b0.wdrop_l;
  assign wdl[1] = b1.wdrop_l;
  assign wdr[0] = b0.wdrop_r;
  assign wdr[1] = b1.wdrop_r;
  assign col[0] = b0.coll;
  assign col[1] = b1.coll;
  assign rdy[0] = b0.ready;
  assign rdy[1] = b1.ready;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic       rql, input logic wel,
    input logic [3:0] al,  input logic [7:0] dl,
    input logic       rqr, input logic wer,
    input logic [3:0] ar,  input logic [7:0] dr
  );
    b0.req_l = rql; b0.we_l = wel; b0.addr_l = al; b0.wdata_l = dl;
    b0.req_r = rqr; b0.we_r = wer; b0.addr_r = ar; b0.wdata_r = dr;
    b1.req_l = rql; b1.we_l = wel; b1.addr_l = al; b1.wdata_l = dl;
    b1.req_r = rqr; b1.we_r = wer; b1.addr_r = ar; b1.wdata_r = dr;
  endtask

  task automatic idle;
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({rdy[d], rvl[d], rvr[d], wdl[d], wdr[d], col[d]} !== 6'b0
          || rdl[d] !== 8'h00 || rdr[d] !== 8'h00) begin
        n_bad++;
        $display("FAIL reset dut%0d: got rdy=%b rv=%b%b wd=%b%b coll=%b rd=%h/%h want all 0",
                 d, rdy[d], rvl[d], rvr[d], wdl[d], wdr[d], col[d], rdl[d], rdr[d]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_init;
    int n;
    wait_ready(n);
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL first_sweep: got %0d edges want 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 4'(i), 8'hAA, 0, 0, 4'h0, 8'h00);
      tick();
    end
    drive(1, 0, 4'h5, 8'h00, 0, 0, 4'h0, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdl[d] !== 8'hAA || rvl[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL preload dut%0d: got %h/%b want aa/1", d, rdl[d], rvl[d]);
      end
    end
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_ready(n);
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL init_sweep: got %0d edges want 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 4'(i), 8'h00, 1, 0, 4'(15 - i), 8'h00);
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (rdl[d] !== 8'h00 || rdr[d] !== 8'h00
            || rvl[d] !== 1'b1 || rvr[d] !== 1'b1) begin
          n_bad++;
          $display("FAIL init_zero dut%0d a%0d: got %h/%h rv=%b%b want 00/00 rv=11",
                   d, i, rdl[d], rdr[d], rvl[d], rvr[d]);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_independent;
    drive(1, 1, 4'h3, 8'h5A, 1, 1, 4'h9, 8'hC3);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (col[d] !== 1'b0 || wdl[d] !== 1'b0 || wdr[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL indep_wr dut%0d: got coll=%b wd=%b%b want 0 00",
                 d, col[d], wdl[d], wdr[d]);
      end
    end
    drive(1, 0, 4'h9, 8'h00, 1, 0, 4'h3, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdl[d] !== 8'hC3 || rdr[d] !== 8'h5A || rvl[d] !== 1'b1
          || rvr[d] !== 1'b1 || col[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL indep_rd dut%0d: got %h/%h rv=%b%b coll=%b want c3/5a rv=11 coll=0",
                 d, rdl[d], rdr[d], rvl[d], rvr[d], col[d]);
      end
    end
    idle();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rvl[d] !== 1'b0 || rvr[d] !== 1'b0
          || rdl[d] !== 8'hC3 || rdr[d] !== 8'h5A) begin
        n_bad++;
        $display("FAIL rd_hold dut%0d: got rv=%b%b %h/%h want rv=00 c3/5a",
                 d, rvl[d], rvr[d], rdl[d], rdr[d]);
      end
    end
  endtask

  task automatic test_rw_collision;
    logic [7:0] exp;
    drive(1, 1, 4'h7, 8'h11, 0, 0, 4'h0, 8'h00);
    tick();
    drive(1, 1, 4'h7, 8'h22, 1, 0, 4'h7, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      exp = (d == 0) ? 8'h11 : 8'h22;
      n_cmp++;
      if (rdr[d] !== exp || col[d] !== 1'b1 || rvr[d] !== 1'b1
          || wdl[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL rw_coll dut%0d: got %h coll=%b rv=%b wdl=%b want %h 1 1 0",
                 d, rdr[d], col[d], rvr[d], wdl[d], exp);
      end
    end
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdr[d] !== 8'h22 || col[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL rw_commit dut%0d: got %h coll=%b want 22 0", d, rdr[d], col[d]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_ww_collision;
    logic [1:0] exp_l;
    logic [1:0] exp_r;
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 4'h5, 8'(2 * c + 1), 1, 1, 4'h5, 8'(2 * c + 2));
      tick();
      exp_l = {c == 1, 1'b0};
      exp_r = {c != 1, 1'b1};
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (wdl[d] !== exp_l[d] || wdr[d] !== exp_r[d] || col[d] !== 1'b1) begin
          n_bad++;
          $display("FAIL ww_c%0d dut%0d: got wd=%b%b coll=%b want %b%b 1",
                   c, d, wdl[d], wdr[d], col[d], exp_l[d], exp_r[d]);
        end
      end
    end
    drive(1, 0, 4'h5, 8'h00, 0, 0, 4'h0, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdl[d] !== 8'h05 || wdl[d] !== 1'b0 || wdr[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL ww_final dut%0d: got %h wd=%b%b want 05 00",
                 d, rdl[d], wdl[d], wdr[d]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1, 1, 4'hA, 8'hB0, 1, 1, 4'hB, 8'hB1);
    tick();
    drive(1, 1, 4'hC, 8'hB2, 1, 0, 4'hA, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdr[d] !== 8'hB0 || rvr[d] !== 1'b1 || rvl[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_1 dut%0d: got %h rv=%b%b want b0 rv=01",
                 d, rdr[d], rvl[d], rvr[d]);
      end
    end
    drive(1, 0, 4'hC, 8'h00, 1, 0, 4'hB, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdl[d] !== 8'hB2 || rdr[d] !== 8'hB1
          || rvl[d] !== 1'b1 || rvr[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_2 dut%0d: got %h/%h rv=%b%b want b2/b1 rv=11",
                 d, rdl[d], rdr[d], rvl[d], rvr[d]);
      end
    end
    drive(1, 0, 4'hA, 8'h00, 1, 0, 4'hC, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdl[d] !== 8'hB0 || rdr[d] !== 8'hB2
          || rvl[d] !== 1'b1 || rvr[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_3 dut%0d: got %h/%h rv=%b%b want b0/b2 rv=11",
                 d, rdl[d], rdr[d], rvl[d], rvr[d]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid;
    int n;
    drive(1, 0, 4'h3, 8'h00, 1, 0, 4'h9, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rvl[d] !== 1'b0 || rvr[d] !== 1'b0 || rdl[d] !== 8'h00
          || rdr[d] !== 8'h00 || rdy[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_rst dut%0d: got rv=%b%b rd=%h/%h rdy=%b want 00 00/00 0",
                 d, rvl[d], rvr[d], rdl[d], rdr[d], rdy[d]);
      end
    end
    drive(1, 1, 4'h2, 8'h77, 1, 0, 4'h4, 8'h00);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 40) begin
      drive(1, 1, 4'h2, 8'h77, 1, 1, 4'h4, 8'h66);
      tick();
      n++;
      for (int d = 0; d < 2; d++) begin
        if (rvr[d] !== 1'b0 || rvl[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL sweep_rv dut%0d: got rv=%b%b want 00", d, rvl[d], rvr[d]);
        end
      end
      n_cmp++;
      drive(1, 0, 4'h2, 8'h00, 1, 0, 4'h4, 8'h00);
      if (n < 16) begin
        tick();
        n++;
        n_cmp++;
        if (rvr[0] !== 1'b0 || rvr[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL sweep_rd: got rv=%b%b want 00", rvr[0], rvr[1]);
        end
      end
    end
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL mid_sweep: got %0d edges want 16", n);
    end
    drive(1, 0, 4'h2, 8'h00, 1, 0, 4'h4, 8'h00);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rdl[d] !== 8'h00 || rdr[d] !== 8'h00
          || rvl[d] !== 1'b1 || rvr[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL sweep_mem dut%0d: got %h/%h rv=%b%b want 00/00 rv=11",
                 d, rdl[d], rdr[d], rvl[d], rvr[d]);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init();
    test_independent();
    test_rw_collision();
    test_ww_collision();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
